// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming 2-D convolution, one MAC per cycle, ready/valid output
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a job (sampled only in IDLE)
//   busy, done          job in progress / one-cycle completion pulse
//   matrix, kernel      input map [CIN][HEIGHT][WIDTH], weights [CIN][K][K]; held by driver while busy
//   bias                accumulator start value for every output pixel
//   out_pixel           result, with out_row/out_col coordinates
//   out_valid/out_ready output handshake; results hold while out_ready is low
module conv2d_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int HEIGHT     = 4,
    parameter int WIDTH      = 4,
    parameter int K          = 2,
    parameter int CIN        = 1,
    parameter int STRIDE     = 1,
    parameter int PAD        = 0,
    parameter int RELU       = 0,
    localparam int CW = $clog2((HEIGHT > WIDTH) ? HEIGHT : WIDTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic signed [DATA_WIDTH-1:0] matrix [0:CIN-1][0:HEIGHT-1][0:WIDTH-1],
    input  logic signed [DATA_WIDTH-1:0] kernel [0:CIN-1][0:K-1][0:K-1],
    input  logic signed [ACC_WIDTH-1:0]  bias,
    output logic signed [ACC_WIDTH-1:0]  out_pixel,
    output logic [CW-1:0]                out_row,
    output logic [CW-1:0]                out_col,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int OUT_H = (HEIGHT + 2 * PAD - K) / STRIDE + 1;
    localparam int OUT_W = (WIDTH + 2 * PAD - K) / STRIDE + 1;
    localparam int CINW  = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CLW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

    state_t                        state_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic [CINW-1:0]               c_q;
    logic [KW-1:0]                 i_q;
    logic [KW-1:0]                 j_q;
    logic [CW-1:0]                 row_q;
    logic [CW-1:0]                 col_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          valid_q;
    logic signed [ACC_WIDTH-1:0]   pixel_q;
    logic [CW-1:0]                 orow_q;
    logic [CW-1:0]                 ocol_q;

    int                            tap_r;
    int                            tap_c;
    logic                          in_bounds;
    logic [RW-1:0]                 r_idx;
    logic [CLW-1:0]                c_idx;
    logic signed [DATA_WIDTH-1:0]  tap_pix;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   sum_d;
    logic signed [ACC_WIDTH-1:0]   result_d;
    logic                          last_tap;
    logic                          last_out;

    // Tap address in the unpadded map; padding taps are detected here and
    // replaced by zero, with the array index parked at 0 so no read goes out of range.
    always_comb begin
        tap_r     = int'(row_q) * STRIDE + int'(i_q) - PAD;
        tap_c     = int'(col_q) * STRIDE + int'(j_q) - PAD;
        in_bounds = (tap_r >= 0) && (tap_r < HEIGHT) && (tap_c >= 0) && (tap_c < WIDTH);
        r_idx     = in_bounds ? tap_r[RW-1:0] : '0;
        c_idx     = in_bounds ? tap_c[CLW-1:0] : '0;
        tap_pix   = in_bounds ? matrix[c_q][r_idx][c_idx] : '0;
        prod      = tap_pix * kernel[c_q][i_q][j_q];
        // Signed size cast sign-extends the full-width product; the add wraps.
        sum_d     = acc_q + ACC_WIDTH'(prod);
        result_d  = ((RELU != 0) && sum_d[ACC_WIDTH-1]) ? '0 : sum_d;
        last_tap  = (c_q == CINW'(CIN - 1)) && (i_q == KW'(K - 1)) && (j_q == KW'(K - 1));
        last_out  = (row_q == CW'(OUT_H - 1)) && (col_q == CW'(OUT_W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            pixel_q <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= bias;
                        c_q     <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= sum_d;
                    if (last_tap) begin
                        pixel_q <= result_d;
                        orow_q  <= row_q;
                        ocol_q  <= col_q;
                        valid_q <= 1'b1;
                        c_q     <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= EMIT;
                    end else if (j_q == KW'(K - 1)) begin
                        j_q <= '0;
                        if (i_q == KW'(K - 1)) begin
                            i_q <= '0;
                            c_q <= c_q + 1'b1;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (last_out) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            acc_q <= bias;
                            if (col_q == CW'(OUT_W - 1)) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                            state_q <= MAC;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_pixel = pixel_q;
    assign out_row   = orow_q;
    assign out_col   = ocol_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - scoreboard bench for conv2d_stream across four parameter sets
module tb_conv2d_stream;

    typedef struct {
        int     row;
        int     col;
        longint pix;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [3:0]        start_v;
    logic [3:0]        ready_v;
    logic [3:0]        busy_v;
    logic [3:0]        done_v;
    logic [3:0]        valid_v;
    logic [3:0][31:0]  pix_v;
    logic [3:0][2:0]   row_v;
    logic [3:0][2:0]   col_v;

    logic signed [7:0]  m0 [0:0][0:3][0:3];
    logic signed [7:0]  k0 [0:0][0:1][0:1];
    logic signed [31:0] b0;
    logic signed [7:0]  m1 [0:1][0:3][0:3];
    logic signed [7:0]  k1 [0:1][0:1][0:1];
    logic signed [31:0] b1;
    logic signed [7:0]  m2 [0:0][0:3][0:3];
    logic signed [7:0]  k2 [0:0][0:2][0:2];
    logic signed [31:0] b2;
    logic signed [7:0]  m3 [0:0][0:3][0:3];
    logic signed [7:0]  k3 [0:0][0:1][0:1];
    logic signed [31:0] b3;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    conv2d_stream u_d0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .matrix(m0), .kernel(k0), .bias(b0), .out_pixel(pix_v[0]),
        .out_row(row_v[0]), .out_col(col_v[0]), .out_valid(valid_v[0]), .out_ready(ready_v[0])
    );

    conv2d_stream #(.CIN(2)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .matrix(m1), .kernel(k1), .bias(b1), .out_pixel(pix_v[1]),
        .out_row(row_v[1]), .out_col(col_v[1]), .out_valid(valid_v[1]), .out_ready(ready_v[1])
    );

    conv2d_stream #(.K(3), .STRIDE(2), .PAD(1)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .matrix(m2), .kernel(k2), .bias(b2), .out_pixel(pix_v[2]),
        .out_row(row_v[2]), .out_col(col_v[2]), .out_valid(valid_v[2]), .out_ready(ready_v[2])
    );

    conv2d_stream #(.RELU(1)) u_d3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .matrix(m3), .kernel(k3), .bias(b3), .out_pixel(pix_v[3]),
        .out_row(row_v[3]), .out_col(col_v[3]), .out_valid(valid_v[3]), .out_ready(ready_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input int c, input longint p);
        exp_t e;
        e.row = r;
        e.col = c;
        e.pix = p;
        sb.push_back(e);
    endtask

    task automatic push3x3(input longint p [9]);
        for (int n = 0; n < 9; n++) push(n / 3, n % 3, p[n]);
    endtask

    // Default-parameter reference: 4x4 map, 2x2 kernel, no padding, unit stride.
    task automatic push_golden_d0();
        for (int r = 0; r < 3; r++) begin
            for (int q = 0; q < 3; q++) begin
                int s;
                s = b0;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        s += int'(m0[0][r+i][q+j]) * int'(k0[0][i][j]);
                push(r, q, longint'(s));
            end
        end
    endtask

    task automatic run_job(input int s, input int n_taps, input int stall);
        int   cnt;
        exp_t e;
        bit   first;
        first      = 1'b1;
        ready_v[s] = (stall == 0);
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        while (sb.size() > 0) begin
            cnt = 0;
            while (!valid_v[s] && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            chk("latency", cnt, n_taps);
            if (!valid_v[s]) begin
                sb.delete();
                break;
            end
            e = sb.pop_front();
            chk("pixel", longint'($signed(pix_v[s])), e.pix);
            chk("row", row_v[s], e.row);
            chk("col", col_v[s], e.col);
            if (first && stall > 0) begin
                repeat (stall) begin
                    @(negedge clk);
                    chk("hold_valid", valid_v[s], 1);
                    chk("hold_pixel", longint'($signed(pix_v[s])), e.pix);
                    chk("hold_row", row_v[s], e.row);
                    chk("hold_col", col_v[s], e.col);
                end
                ready_v[s] = 1'b1;
            end
            first = 1'b0;
            @(negedge clk);
            chk("valid_drop", valid_v[s], 0);
        end
        chk("done_pulse", done_v[s], 1);
        chk("busy_in_done", busy_v[s], 1);
        @(negedge clk);
        chk("done_clear", done_v[s], 0);
        chk("busy_clear", busy_v[s], 0);
    endtask

    task automatic load_ramp_d0();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m0[0][r][c] = 8'(r * 4 + c + 1);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                k0[0][i][j] = 8'sd1;
        b0 = 0;
    endtask

    initial begin
        longint ref025 [9];
        longint ref026 [9];
        longint zeros  [9];
        longint negs   [9];
        int     cnt;
        ref025 = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
        ref026 = '{15, 19, 23, 31, 35, 39, 47, 51, 55};
        zeros  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        negs   = '{-4, -4, -4, -4, -4, -4, -4, -4, -4};
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start_v = '0;
        ready_v = '1;

        load_ramp_d0();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                m1[0][r][c] = 8'(r * 4 + c + 1);
                m1[1][r][c] = 8'sd1;
                m2[0][r][c] = 8'sd1;
                m3[0][r][c] = 8'sd1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                k1[0][i][j] = 8'sd1;
                k1[1][i][j] = -8'sd1;
                k3[0][i][j] = -8'sd1;
            end
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                k2[0][i][j] = 8'sd1;
        b1 = 5;
        b2 = 0;
        b3 = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_done", done_v[0], 0);
        chk("rst_valid", valid_v[0], 0);
        chk("rst_pixel", longint'($signed(pix_v[0])), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic ramp, 2x2 ones kernel
        push3x3(ref025);
        run_job(0, 4, 0);

        // Two channels, bias 5
        push3x3(ref026);
        run_job(1, 8, 0);

        // Padding and stride
        push(0, 0, 4);
        push(0, 1, 6);
        push(1, 0, 6);
        push(1, 1, 9);
        run_job(2, 9, 0);

        // ReLU clamps negative sums
        push3x3(zeros);
        run_job(3, 4, 0);

        // Same negative case without ReLU
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m0[0][r][c] = 8'sd1;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                k0[0][i][j] = -8'sd1;
        push3x3(negs);
        run_job(0, 4, 0);

        // Back-pressure on the first result
        load_ramp_d0();
        push3x3(ref025);
        run_job(0, 4, 5);

        // Reset during MAC of the second output
        ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cnt = 0;
        while (!valid_v[0] && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_first_pixel", longint'($signed(pix_v[0])), 14);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy_v[0], 0);
        chk("abort_valid", valid_v[0], 0);
        chk("abort_pixel", longint'($signed(pix_v[0])), 0);
        chk("abort_row", row_v[0], 0);
        chk("abort_col", col_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_done", done_v[0], 0);
            chk("abort_no_valid", valid_v[0], 0);
        end
        push3x3(ref025);
        run_job(0, 4, 0);

        // Random maps, weights and bias against the reference
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    m0[0][r][c] = 8'($urandom);
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    k0[0][i][j] = 8'($urandom);
            b0 = (t == 3) ? 32'sh7fff_fff0 : 32'($urandom_range(0, 2000)) - 1000;
            push_golden_d0();
            run_job(0, 4, 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed pixel/weight width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, signed accumulator/result width.
REQ-003 SHALL have parameters HEIGHT, WIDTH, defaults 4, 4, input map size per channel.
REQ-004 SHALL have parameter K, default 2, square kernel size.
REQ-005 SHALL have parameter CIN, default 1, input channel count (>=1).
REQ-006 SHALL have parameters STRIDE, default 1 (>=1), and PAD, default 0, the zero-padding border width.
REQ-007 SHALL have parameter RELU, default 0; 1 clamps negative results to 0.
REQ-008 Ports: clk in 1, the only clock; rst in 1, asynchronous active-high reset.
REQ-009 Ports: start in 1, begin job; busy out 1, job in progress; done out 1, job-complete pulse.
REQ-010 Ports: matrix in signed DATA_WIDTH [0:CIN-1][0:HEIGHT-1][0:WIDTH-1]; kernel in signed DATA_WIDTH [0:CIN-1][0:K-1][0:K-1]; bias in signed ACC_WIDTH.
REQ-011 Ports: out_pixel out signed ACC_WIDTH; out_row, out_col out $clog2(max(HEIGHT,WIDTH))+1 bits, output coordinates; out_valid out 1; out_ready in 1.

Function
REQ-012 OUT_H=(HEIGHT+2*PAD-K)/STRIDE+1 and OUT_W=(WIDTH+2*PAD-K)/STRIDE+1, integer division; outputs SHALL be emitted row-major, (0,0) first.
REQ-013 States SHALL be IDLE, MAC, EMIT, DONE.
REQ-014 IDLE: start high at an edge SHALL load acc=bias, zero coordinates and tap counters, set busy=1, go to MAC; start SHALL be ignored in every other state.
REQ-015 MAC SHALL add one product per cycle, iterating c outer, i middle, j inner, N=CIN*K*K cycles per output.
REQ-016 Tap (c,i,j) for output (r,q) SHALL read matrix[c][r*STRIDE+i-PAD][q*STRIDE+j-PAD]; out-of-bounds taps SHALL contribute 0 without out-of-range array access.
REQ-017 Products SHALL be full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH; accumulation SHALL wrap two's-complement modulo 2^ACC_WIDTH.
REQ-018 On the Nth MAC edge the final sum (post-ReLU if RELU=1) SHALL be registered to out_pixel with out_row/out_col, out_valid set to 1, state to EMIT; out_valid is thus first high N cycles after the start edge.
REQ-019 EMIT: out_valid, out_pixel, out_row, out_col SHALL hold stable while out_ready is low.
REQ-020 EMIT with out_ready high at an edge: out_valid SHALL drop; if more outputs remain, acc=bias, coordinates advance (col wraps to 0 and row increments after OUT_W-1), state MAC; otherwise state DONE. Steady throughput with out_ready high SHALL be one output per N+1 cycles.
REQ-021 DONE SHALL last exactly one cycle with done=1, then IDLE with busy=0, done=0.
REQ-022 matrix, kernel, bias SHALL be held stable by the driver while busy=1; the block SHALL NOT copy them.

Reset
REQ-023 rst high SHALL asynchronously force state IDLE and busy, done, out_valid, out_pixel, out_row, out_col, acc and all counters to 0, including mid-MAC or mid-EMIT; no partial job resumes.
REQ-024 After rst deasserts, the first start SHALL begin a fresh job per REQ-014.

Verification
REQ-025 4x4, K=2, CIN=1, STRIDE=1, PAD=0, matrix 1..16 row-major, kernel all 1, bias 0, out_ready=1 -> 14,18,22,30,34,38,46,50,54, first out_valid 4 cycles after start, done one cycle after final handshake.
REQ-026 Same, CIN=2, channel 1 all 1, kernel channel 1 all -1, bias 5 -> 15,19,23,31,35,39,47,51,55.
REQ-027 4x4 all 1, K=3, STRIDE=2, PAD=1, kernel all 1, bias 0 -> 2x2 outputs 4,6,6,9 with coords (0,0),(0,1),(1,0),(1,1).
REQ-028 out_ready low 5 cycles during first EMIT -> out_valid=1, out_pixel=14, coords (0,0) unchanged all 5 cycles; sequence then resumes intact.
REQ-029 RELU=1, kernel all -1, matrix all 1, bias 0 -> every out_pixel 0; RELU=0 -> every out_pixel -4.
REQ-030 rst pulsed during MAC of second output -> all outputs 0 immediately, no done; a later start reproduces REQ-025 exactly.
